// File: rtl/mprj_io_ctrl_pkg.sv
// Shared constants and helpers for the user-project IO control block.
// Holds the pad count, register offsets, CTRL bit positions and the counter ceiling.
package mprj_io_ctrl_pkg;

  localparam int NUM_IO = 38;

  localparam logic [7:0] OFS_OUT_LO  = 8'h00;
  localparam logic [7:0] OFS_OUT_HI  = 8'h04;
  localparam logic [7:0] OFS_OEB_LO  = 8'h08;
  localparam logic [7:0] OFS_OEB_HI  = 8'h0C;
  localparam logic [7:0] OFS_IN_LO   = 8'h10;
  localparam logic [7:0] OFS_IN_HI   = 8'h14;
  localparam logic [7:0] OFS_EDGE_LO = 8'h18;
  localparam logic [7:0] OFS_EDGE_HI = 8'h1C;
  localparam logic [7:0] OFS_CNT     = 8'h20;
  localparam logic [7:0] OFS_CTRL    = 8'h24;

  localparam int CTRL_SEL_LSB = 0;
  localparam int CTRL_SEL_MSB = 5;
  localparam int SEL_W        = CTRL_SEL_MSB - CTRL_SEL_LSB + 1;
  localparam int CTRL_CNT_CLR = 8;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Expand the four Wishbone byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdat,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (wdat & mask);
  endfunction

endpackage

// File: rtl/mprj_io_ctrl_io_sync_edge.sv
// Two-flop synchronizer for the asynchronous pad inputs, followed by a
// previous-value flop that yields a one-cycle rising-edge strobe per bit.
module io_sync_edge #(
  parameter int W = 38
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/mprj_io_ctrl.sv
// Wishbone-mapped control of the user IO pads: output/enable registers,
// synchronized input view, sticky rising-edge flags and a selectable edge counter.
module mprj_io_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          NUM_IO   = mprj_io_ctrl_pkg::NUM_IO
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              io_active,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb
);

  import mprj_io_ctrl_pkg::*;

  localparam int HI_W = NUM_IO - 32;

  logic              w_sel;
  logic              w_wr;
  logic              w_rd_lat;
  logic [7:0]        w_ofs;
  logic [31:0]       w_lmask;
  logic [31:0]       w_rdata;
  logic [NUM_IO-1:0] w_sync;
  logic [NUM_IO-1:0] w_rise;
  logic [NUM_IO-1:0] w_edge_clr;
  logic              w_cnt_rise;
  logic              w_cnt_clr;

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [NUM_IO-1:0] r_out;
  logic [NUM_IO-1:0] r_oeb;
  logic [NUM_IO-1:0] r_edge;
  logic [31:0]       r_cnt;
  logic [SEL_W-1:0]  r_sel;

  io_sync_edge #(.W(NUM_IO)) u_sync_edge (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_async (io_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_sel    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_ofs    = wbs_adr_i[7:0];
  assign w_lmask  = lane_mask(wbs_sel_i);
  // Writes land at the edge closing the ack cycle; read data is captured at the edge opening it.
  assign w_wr     = w_sel & r_ack & wbs_we_i;
  assign w_rd_lat = w_sel & ~r_ack & ~wbs_we_i;

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_OUT_LO:  w_rdata = r_out[31:0];
      OFS_OUT_HI:  w_rdata = 32'(r_out[NUM_IO-1:32]);
      OFS_OEB_LO:  w_rdata = r_oeb[31:0];
      OFS_OEB_HI:  w_rdata = 32'(r_oeb[NUM_IO-1:32]);
      OFS_IN_LO:   w_rdata = w_sync[31:0];
      OFS_IN_HI:   w_rdata = 32'(w_sync[NUM_IO-1:32]);
      OFS_EDGE_LO: w_rdata = r_edge[31:0];
      OFS_EDGE_HI: w_rdata = 32'(r_edge[NUM_IO-1:32]);
      OFS_CNT:     w_rdata = r_cnt;
      OFS_CTRL:    w_rdata = 32'(r_sel) << CTRL_SEL_LSB;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_sel & ~r_ack;
      r_dat <= w_rd_lat ? w_rdata : '0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_out <= '0;
      r_oeb <= '1;
      r_sel <= '0;
    end else if (w_wr) begin
      case (w_ofs)
        OFS_OUT_LO: r_out[31:0] <= lane_merge(r_out[31:0], wbs_dat_i, w_lmask);
        OFS_OUT_HI: r_out[NUM_IO-1:32] <= (r_out[NUM_IO-1:32] & ~w_lmask[HI_W-1:0]) |
                                          (wbs_dat_i[HI_W-1:0] & w_lmask[HI_W-1:0]);
        OFS_OEB_LO: r_oeb[31:0] <= lane_merge(r_oeb[31:0], wbs_dat_i, w_lmask);
        OFS_OEB_HI: r_oeb[NUM_IO-1:32] <= (r_oeb[NUM_IO-1:32] & ~w_lmask[HI_W-1:0]) |
                                          (wbs_dat_i[HI_W-1:0] & w_lmask[HI_W-1:0]);
        OFS_CTRL: begin
          if (wbs_sel_i[CTRL_SEL_LSB / 8]) r_sel <= wbs_dat_i[CTRL_SEL_MSB:CTRL_SEL_LSB];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_edge_clr = '0;
    if (w_wr && w_ofs == OFS_EDGE_LO) w_edge_clr[31:0] = wbs_dat_i & w_lmask;
    if (w_wr && w_ofs == OFS_EDGE_HI) w_edge_clr[NUM_IO-1:32] = wbs_dat_i[HI_W-1:0] & w_lmask[HI_W-1:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_edge <= '0;
    end else begin
      // A new edge outranks a simultaneous write-1-to-clear on the same bit.
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

  always_comb begin
    w_cnt_rise = 1'b0;
    if (int'(r_sel) < NUM_IO) w_cnt_rise = w_rise[r_sel];
  end

  assign w_cnt_clr = w_wr & (w_ofs == OFS_CTRL) & wbs_sel_i[CTRL_CNT_CLR / 8] &
                     wbs_dat_i[CTRL_CNT_CLR];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_rise && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Global enable gates the pads combinationally; the registers keep their contents.
  assign io_out = io_active ? r_out : '0;
  assign io_oeb = io_active ? r_oeb : '1;

endmodule
